// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin sequencer for the shared yAlu datapath.
// Define ALU_ARB_OPCHECK_EN to flag unsupported ops with rsp_err instead of issuing them.
module alu_arbiter #(
  parameter int unsigned ALU_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req0_op,
  input  logic [2:0]  req1_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_z,
  input  logic        alu_ex,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_z,
  output logic        rsp_ex,
  output logic        rsp_id,
  output logic        rsp_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_z_q, rsp_z_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic        rsp_ex_q, rsp_ex_d, rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
  logic        win, acc, bad_op;
  logic [31:0] sel_a, sel_b;
  logic [2:0]  sel_op;
  always_comb begin
    win        = rst_n && (state_q == IDLE || (state_q == HOLD && rsp_ready));
    // ties go to whoever was not served last
    req0_ready = win && req0_valid && (!req1_valid || last_grant_q);
    req1_ready = win && req1_valid && (!req0_valid || !last_grant_q);
    acc        = req0_ready || req1_ready;
    sel_a      = req1_ready ? req1_a : req0_a;
    sel_b      = req1_ready ? req1_b : req0_b;
    sel_op     = req1_ready ? req1_op : req0_op;
`ifdef ALU_ARB_OPCHECK_EN
    bad_op     = !(sel_op inside {3'b000, 3'b001, 3'b010, 3'b110});
`else
    bad_op     = 1'b0;
`endif
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_z_d      = rsp_z_q;
    rsp_ex_d     = rsp_ex_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    if (acc) begin
      last_grant_d = req1_ready;
      rsp_id_d     = req1_ready;
      cnt_d        = 4'(ALU_WAIT);
      if (bad_op) begin
        state_d   = HOLD;
        rsp_z_d   = '0;
        rsp_ex_d  = 1'b0;
        rsp_err_d = 1'b1;
      end else begin
        state_d  = ISSUE;
        alu_a_d  = sel_a;
        alu_b_d  = sel_b;
        alu_op_d = sel_op;
      end
    end else if (state_q == HOLD && rsp_ready) begin
      state_d = IDLE;
    end else if (state_q == ISSUE) begin
      if (cnt_q == 4'd0) begin
        state_d   = HOLD;
        rsp_z_d   = alu_z;
        rsp_ex_d  = alu_ex;
        rsp_err_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_z_q      <= '0;
      rsp_ex_q     <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_z_q      <= rsp_z_d;
      rsp_ex_q     <= rsp_ex_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
    end
  end
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = state_q == HOLD;
  assign rsp_z     = rsp_z_q;
  assign rsp_ex    = rsp_ex_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with ALU_WAIT=0 and ALU_WAIT=3 instances.
module tb_alu_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b0;
  logic r0v = 1'b0, r1v = 1'b0, q0v = 1'b0, zv = 1'b0;
  logic [31:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0, q0a = '0, q0b = '0, zd = '0;
  logic [2:0]  r0op = '0, r1op = '0, q0op = '0, zop = '0;
  logic        d0_r0rdy, d0_r1rdy, d0_v, d0_ex, d0_id, d0_err;
  logic [31:0] d0_a, d0_b, d0_z, z0;
  logic [2:0]  d0_op;
  logic        d3_r0rdy, d3_r1rdy, d3_v, d3_ex, d3_id, d3_err;
  logic [31:0] d3_a, d3_b, d3_z, z3;
  logic [2:0]  d3_op;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    return op == 3'b000 ? (a & b) : op == 3'b001 ? (a | b) : op == 3'b010 ? a + b :
           op == 3'b110 ? a - b : (a ^ b);
  endfunction
  assign z0 = alu_f(d0_a, d0_b, d0_op);
  assign z3 = alu_f(d3_a, d3_b, d3_op);
  alu_arbiter #(.ALU_WAIT(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req1_valid(r1v), .req0_ready(d0_r0rdy), .req1_ready(d0_r1rdy),
    .req0_a(r0a), .req0_b(r0b), .req1_a(r1a), .req1_b(r1b), .req0_op(r0op), .req1_op(r1op),
    .alu_a(d0_a), .alu_b(d0_b), .alu_op(d0_op), .alu_z(z0), .alu_ex(z0 == 32'd0),
    .rsp_valid(d0_v), .rsp_ready(rsp_ready), .rsp_z(d0_z), .rsp_ex(d0_ex), .rsp_id(d0_id), .rsp_err(d0_err)
  );
  alu_arbiter #(.ALU_WAIT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(q0v), .req1_valid(zv), .req0_ready(d3_r0rdy), .req1_ready(d3_r1rdy),
    .req0_a(q0a), .req0_b(q0b), .req1_a(zd), .req1_b(zd), .req0_op(q0op), .req1_op(zop),
    .alu_a(d3_a), .alu_b(d3_b), .alu_op(d3_op), .alu_z(z3), .alu_ex(z3 == 32'd0),
    .rsp_valid(d3_v), .rsp_ready(rsp_ready), .rsp_z(d3_z), .rsp_ex(d3_ex), .rsp_id(d3_id), .rsp_err(d3_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    r0v = 1'b1;
    #1;
    chk("rst_r0rdy", 32'(d0_r0rdy), 0);
    chk("rst_v", 32'(d0_v), 0);
    chk("rst_err", 32'(d0_err), 0);
    chk("rst_alu_a", d0_a, 0);
    chk("rst_alu_op", 32'(d0_op), 0);
    chk("rst_z", d0_z, 0);
    chk("rst_id", 32'(d0_id), 0);
    r0v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // single add
    r0v = 1'b1; r0a = 32'h5; r0b = 32'h3; r0op = 3'b010;
    #1;
    chk("add_rdy", 32'(d0_r0rdy), 1);
    step();
    r0v = 1'b0;
    chk("add_issue_v", 32'(d0_v), 0);
    chk("add_alu_a", d0_a, 32'h5);
    step();
    chk("add_v", 32'(d0_v), 1);
    chk("add_z", d0_z, 32'h8);
    chk("add_id", 32'(d0_id), 0);
    chk("add_err", 32'(d0_err), 0);
    rsp_ready = 1'b1;
    step();
    chk("add_idle_v", 32'(d0_v), 0);
    // tie after reset, alternating grants
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    r0v = 1'b1; r0a = 32'hF0F0F0F0; r0b = 32'hFF00FF00; r0op = 3'b000;
    r1v = 1'b1; r1a = 32'h12340000; r1b = 32'h00005678; r1op = 3'b001;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("tie_r0rdy%0d", i), 32'(d0_r0rdy), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("tie_r1rdy%0d", i), 32'(d0_r1rdy), (i % 2 == 1) ? 1 : 0);
      step();
      step();
      chk($sformatf("tie_v%0d", i), 32'(d0_v), 1);
      chk($sformatf("tie_id%0d", i), 32'(d0_id), i % 2);
      chk($sformatf("tie_z%0d", i), d0_z, (i % 2 == 0) ? 32'hF000F000 : 32'h12345678);
    end
    r0v = 1'b0; r1v = 1'b0;
    step();
    // back-pressure with req1 waiting
    rsp_ready = 1'b0;
    r0v = 1'b1; r0a = 32'd10; r0b = 32'd20; r0op = 3'b010;
    step();
    r0v = 1'b0;
    r1v = 1'b1; r1a = 32'd100; r1b = 32'd1; r1op = 3'b110;
    #1;
    chk("bp_issue_r1rdy", 32'(d0_r1rdy), 0);
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_v%0d", k), 32'(d0_v), 1);
      chk($sformatf("bp_z%0d", k), d0_z, 32'd30);
      chk($sformatf("bp_r1rdy%0d", k), 32'(d0_r1rdy), 0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_r1rdy", 32'(d0_r1rdy), 1);
    step();
    r1v = 1'b0;
    chk("bp_issue_v", 32'(d0_v), 0);
    chk("bp_id", 32'(d0_id), 1);
    step();
    chk("bp_z2", d0_z, 32'd99);
    step();
    // settle count on the ALU_WAIT=3 instance
    q0v = 1'b1; q0a = 32'h1; q0b = 32'h2; q0op = 3'b110;
    #1;
    chk("wait_rdy", 32'(d3_r0rdy), 1);
    step();
    q0v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wait_a%0d", k), d3_a, 32'h1);
      chk($sformatf("wait_op%0d", k), 32'(d3_op), 32'h6);
      chk($sformatf("wait_v%0d", k), 32'(d3_v), 0);
      step();
    end
    chk("wait_v", 32'(d3_v), 1);
    chk("wait_z", d3_z, 32'hFFFFFFFF);
    chk("wait_ex", 32'(d3_ex), 0);
    step();
    // mid-op reset
    r0v = 1'b1; r0a = 32'd7; r0b = 32'd7; r0op = 3'b010;
    step();
    r0v = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_v", 32'(d0_v), 0);
    chk("mrst_alu_a", d0_a, 0);
    chk("mrst_z", d0_z, 0);
    chk("mrst_id", 32'(d0_id), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("mrst_nov%0d", k), 32'(d0_v), 0);
    end
    r0v = 1'b1; r1v = 1'b1;
    #1;
    chk("mrst_r0rdy", 32'(d0_r0rdy), 1);
    chk("mrst_r1rdy", 32'(d0_r1rdy), 0);
    step();
    r0v = 1'b0; r1v = 1'b0;
    step();
    chk("mrst_z2", d0_z, 32'd14);
    chk("mrst_id2", 32'(d0_id), 0);
    step();
    // unsupported op
    rsp_ready = 1'b0;
    r0v = 1'b1; r0a = 32'd6; r0b = 32'd3; r0op = 3'b111;
    #1;
    chk("bad_rdy", 32'(d0_r0rdy), 1);
    step();
    r0v = 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
    chk("bad_v", 32'(d0_v), 1);
    chk("bad_err", 32'(d0_err), 1);
    chk("bad_z", d0_z, 0);
    chk("bad_alu_op", 32'(d0_op), 32'h2);
`else
    chk("bad_issue_v", 32'(d0_v), 0);
    step();
    chk("bad_v", 32'(d0_v), 1);
    chk("bad_err", 32'(d0_err), 0);
    chk("bad_z", d0_z, 32'd5);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
